dffram512x32_arbiter_2p: RTL and testbench

//  Shares one single-port DFFRAM512x32 macro between two word-level requesters (r0, r1).
//  Per cycle: at most one granted access, selected round-robin.

---
 rtl/dffram512x32_arbiter_2p.sv | 199 +++++++++++++++++++
 tb/tb_dffram512x32_arbiter_2p.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dffram512x32_arbiter_2p.sv
// -----------------------------------------------------------------------------
// dffram512x32_arbiter_2p
//
// Shares one single-port DFFRAM512x32 macro between two word-level requesters.
// At most one access is granted per cycle. Read data comes back to the issuing
// port one cycle after its grant, which matches the macro's read latency.
//
// Optional feature macro: DFFRAM_ARB_FIXED_PRIO_EN
//   defined   : port 0 always wins when both ports request (port 1 may starve)
//   undefined : round-robin between the two ports (default)
//
// Ports
//   CLK        in   clock; also drives the macro clock
//   RST        in   synchronous reset, active-high
//   rN_req     in   port N request; command fields held stable until rN_gnt
//   rN_we      in   port N byte write enables (all zero = read)
//   rN_addr    in   port N word address
//   rN_wdata   in   port N write data
//   rN_gnt     out  port N command accepted this cycle (combinational)
//   rN_rvalid  out  port N read data valid (one-cycle pulse)
//   rN_rdata   out  port N read data, held until the next port N read returns
//   ram_en     out  macro EN0
//   ram_we     out  macro WE0
//   ram_addr   out  macro A0
//   ram_wdata  out  macro Di0
//   ram_rdata  in   macro Do0
// -----------------------------------------------------------------------------
module dffram512x32_arbiter_2p #(
    parameter int AW = 9,
    parameter int DW = 32
) (
    input  logic              CLK,
    input  logic              RST,

    input  logic              r0_req,
    input  logic [DW/8-1:0]   r0_we,
    input  logic [AW-1:0]     r0_addr,
    input  logic [DW-1:0]     r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DW-1:0]     r0_rdata,

    input  logic              r1_req,
    input  logic [DW/8-1:0]   r1_we,
    input  logic [AW-1:0]     r1_addr,
    input  logic [DW-1:0]     r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DW-1:0]     r1_rdata,

    output logic              ram_en,
    output logic [DW/8-1:0]   ram_we,
    output logic [AW-1:0]     ram_addr,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata
);

    localparam int NB = DW / 8;

    // Per-port views so the per-port logic can be generated.
    logic [1:0]          req;
    logic [NB-1:0]       we_a    [2];
    logic [AW-1:0]       addr_a  [2];
    logic [DW-1:0]       wdata_a [2];
    logic [1:0]          gnt;
    logic [1:0]          rvalid;
    logic [DW-1:0]       rdata   [2];
    logic [DW-1:0]       rdata_reg [2];

    assign req        = {r1_req, r0_req};
    assign we_a[0]    = r0_we;
    assign we_a[1]    = r1_we;
    assign addr_a[0]  = r0_addr;
    assign addr_a[1]  = r1_addr;
    assign wdata_a[0] = r0_wdata;
    assign wdata_a[1] = r1_wdata;

    // Read-return tracking: one read can be in flight at a time because the
    // macro accepts one access per cycle with one cycle of latency.
    logic rd_pend_reg, rd_pend_next;
    logic rd_id_reg,   rd_id_next;

`ifndef DFFRAM_ARB_FIXED_PRIO_EN
    // Port that won the most recent grant; resets to 1 so port 0 wins the
    // first tie.
    logic last_gnt_reg, last_gnt_next;
`endif

    // ------------------------------------------------------------------
    // Arbitration. Grants are suppressed while reset is asserted so that
    // nothing reaches the macro during reset.
    // ------------------------------------------------------------------
    always_comb begin
        gnt = 2'b00;
        if (!RST) begin
`ifdef DFFRAM_ARB_FIXED_PRIO_EN
            if (req[0]) begin
                gnt[0] = 1'b1;
            end else if (req[1]) begin
                gnt[1] = 1'b1;
            end
`else
            if (req[0] && req[1]) begin
                // Tie: the port that did not win last time goes now.
                if (last_gnt_reg) begin
                    gnt[0] = 1'b1;
                end else begin
                    gnt[1] = 1'b1;
                end
            end else begin
                gnt = req;
            end
`endif
        end
    end

    // Command mux towards the macro; idle cycles drive zeros.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = '0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt[1]) begin
            ram_en    = 1'b1;
            ram_we    = we_a[1];
            ram_addr  = addr_a[1];
            ram_wdata = wdata_a[1];
        end else if (gnt[0]) begin
            ram_en    = 1'b1;
            ram_we    = we_a[0];
            ram_addr  = addr_a[0];
            ram_wdata = wdata_a[0];
        end
    end

    always_comb begin
        rd_pend_next = ram_en && (ram_we == '0);
        rd_id_next   = rd_id_reg;
        if (ram_en) begin
            rd_id_next = gnt[1];
        end
    end

`ifndef DFFRAM_ARB_FIXED_PRIO_EN
    always_comb begin
        last_gnt_next = last_gnt_reg;
        if (ram_en) begin
            last_gnt_next = gnt[1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_gnt_reg <= 1'b1;
        end else begin
            last_gnt_reg <= last_gnt_next;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_pend_reg <= 1'b0;
            rd_id_reg   <= 1'b0;
        end else begin
            rd_pend_reg <= rd_pend_next;
            rd_id_reg   <= rd_id_next;
        end
    end

    // ------------------------------------------------------------------
    // Per-port read return. The macro output is valid in the cycle after
    // the grant, so rdata is passed straight through during the rvalid
    // cycle and captured so it stays stable afterwards. Reset masks an
    // in-flight return.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_port
            assign rvalid[gi] = rd_pend_reg && (rd_id_reg == 1'(gi)) && !RST;
            assign rdata[gi]  = rvalid[gi] ? ram_rdata : rdata_reg[gi];

            always_ff @(posedge CLK) begin
                if (RST) begin
                    rdata_reg[gi] <= '0;
                end else if (rvalid[gi]) begin
                    rdata_reg[gi] <= ram_rdata;
                end
            end
        end
    endgenerate

    assign r0_gnt    = gnt[0];
    assign r1_gnt    = gnt[1];
    assign r0_rvalid = rvalid[0];
    assign r1_rvalid = rvalid[1];
    assign r0_rdata  = rdata[0];
    assign r1_rdata  = rdata[1];

endmodule

// File: tb/tb_dffram512x32_arbiter_2p.sv
// -----------------------------------------------------------------------------
// tb_dffram512x32_arbiter_2p
//
// Directed bench for the two-port DFFRAM arbiter. A small behavioural model of
// the single-port macro (byte-enabled write, one-cycle registered read) sits
// on the ram_* side. Inputs change on the falling edge; outputs are checked
// 2 time units later, i.e. well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_dffram512x32_arbiter_2p;

    localparam int AW = 9;
    localparam int DW = 32;

    logic            CLK = 1'b0;
    logic            RST;
    logic            r0_req, r1_req;
    logic [3:0]      r0_we, r1_we;
    logic [AW-1:0]   r0_addr, r1_addr;
    logic [DW-1:0]   r0_wdata, r1_wdata;
    logic            r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
    logic [DW-1:0]   r0_rdata, r1_rdata;
    logic            ram_en;
    logic [3:0]      ram_we;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wdata;
    logic [DW-1:0]   ram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    dffram512x32_arbiter_2p #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RST(RST),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural single-port macro.
    logic [DW-1:0] mem [512];
    initial ram_rdata = '0;
    always @(posedge CLK) begin
        if (ram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set0(input logic req, input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] d);
        r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
    endtask

    task automatic set1(input logic req, input logic [3:0] we, input logic [AW-1:0] a, input logic [31:0] d);
        r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
    endtask

    // Finish the current cycle and move to the next drive point.
    task automatic next_cycle();
        @(negedge CLK);
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        RST = 1'b1;
        set0(1'b1, 4'h0, 9'h000, 32'h0);
        set1(1'b1, 4'h0, 9'h000, 32'h0);

        // Reset: requests present, but nothing granted.
        @(negedge CLK); settle();
        chk("rst_r0_gnt", 32'(r0_gnt), 32'd0);
        chk("rst_r1_gnt", 32'(r1_gnt), 32'd0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        next_cycle();
        RST = 1'b0;
        set0(1'b0, 4'h0, 9'h000, 32'h0);
        set1(1'b0, 4'h0, 9'h000, 32'h0);
        settle();
        chk("rst_r0_rdata", r0_rdata, 32'h0);
        chk("rst_r1_rdata", r1_rdata, 32'h0);
        chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
        chk("idle_ram_addr", 32'(ram_addr), 32'd0);
        $display("reset checked");

        // 1: r0 write then read 0x005.
        next_cycle();
        set0(1'b1, 4'hF, 9'h005, 32'hDEADBEEF); settle();
        chk("t1_wr_gnt", 32'(r0_gnt), 32'd1);
        chk("t1_ram_we", 32'(ram_we), 32'hF);
        chk("t1_ram_addr", 32'(ram_addr), 32'h005);
        chk("t1_ram_wdata", ram_wdata, 32'hDEADBEEF);
        $display("t1 r0 write 0x005 <= deadbeef");
        next_cycle();
        set0(1'b1, 4'h0, 9'h005, 32'h0); settle();
        chk("t1_rd_gnt", 32'(r0_gnt), 32'd1);
        chk("t1_no_rvalid_after_wr", 32'(r0_rvalid), 32'd0);
        next_cycle();
        set0(1'b0, 4'h0, 9'h000, 32'h0); settle();
        chk("t1_rvalid", 32'(r0_rvalid), 32'd1);
        chk("t1_rdata", r0_rdata, 32'hDEADBEEF);
        chk("t1_r1_rvalid", 32'(r1_rvalid), 32'd0);
        $display("t1 r0 read 0x005 -> %h", r0_rdata);
        next_cycle(); settle();
        chk("t1_rvalid_pulse", 32'(r0_rvalid), 32'd0);
        chk("t1_rdata_held", r0_rdata, 32'hDEADBEEF);

        // 2: preload 0x001/0x002 via a tied write (last_gnt=0 so r1 wins).
        next_cycle();
        set0(1'b1, 4'hF, 9'h001, 32'h11);
        set1(1'b1, 4'hF, 9'h002, 32'h22); settle();
        chk("t2_tie_r1_gnt", 32'(r1_gnt), 32'd1);
        chk("t2_tie_r0_gnt", 32'(r0_gnt), 32'd0);
        next_cycle();
        set1(1'b0, 4'h0, 9'h000, 32'h0); settle();
        chk("t2_r0_wait1", 32'(r0_gnt), 32'd1);
        next_cycle();
        set0(1'b1, 4'h0, 9'h001, 32'h0);
        set1(1'b1, 4'h0, 9'h002, 32'h0); settle();
        chk("t2_c1_r1_gnt", 32'(r1_gnt), 32'd1);
        chk("t2_c1_r0_gnt", 32'(r0_gnt), 32'd0);
        next_cycle(); settle();
        chk("t2_c2_r0_gnt", 32'(r0_gnt), 32'd1);
        chk("t2_c2_r1_rvalid", 32'(r1_rvalid), 32'd1);
        chk("t2_c2_r1_rdata", r1_rdata, 32'h22);
        $display("t2 r1 read 0x002 -> %h", r1_rdata);
        next_cycle(); settle();
        chk("t2_c3_r1_gnt", 32'(r1_gnt), 32'd1);
        chk("t2_c3_r0_rvalid", 32'(r0_rvalid), 32'd1);
        chk("t2_c3_r0_rdata", r0_rdata, 32'h11);
        chk("t2_c3_r1_rvalid", 32'(r1_rvalid), 32'd0);
        chk("t2_c3_r1_rdata_held", r1_rdata, 32'h22);
        $display("t2 r0 read 0x001 -> %h", r0_rdata);
        next_cycle();
        set0(1'b0, 4'h0, 9'h000, 32'h0);
        set1(1'b0, 4'h0, 9'h000, 32'h0); settle();
        chk("t2_c4_r1_rvalid", 32'(r1_rvalid), 32'd1);
        chk("t2_c4_r1_rdata", r1_rdata, 32'h22);
        chk("t2_c4_r0_rvalid", 32'(r0_rvalid), 32'd0);

        // 3: byte-lane write from r1, read back via r0.
        next_cycle();
        set1(1'b1, 4'b0010, 9'h005, 32'h0000AB00); settle();
        chk("t3_r1_gnt", 32'(r1_gnt), 32'd1);
        next_cycle();
        set1(1'b0, 4'h0, 9'h000, 32'h0);
        set0(1'b1, 4'h0, 9'h005, 32'h0); settle();
        chk("t3_r0_gnt", 32'(r0_gnt), 32'd1);
        next_cycle();
        set0(1'b0, 4'h0, 9'h000, 32'h0); settle();
        chk("t3_rvalid", 32'(r0_rvalid), 32'd1);
        chk("t3_rdata", r0_rdata, 32'hDEADABEF);
        $display("t3 byte write then r0 read 0x005 -> %h", r0_rdata);

        // 6: r1 writes 0x1FF, r0 reads it the very next cycle.
        next_cycle();
        set1(1'b1, 4'hF, 9'h1FF, 32'h12345678); settle();
        chk("t6_r1_gnt", 32'(r1_gnt), 32'd1);
        next_cycle();
        set1(1'b0, 4'h0, 9'h000, 32'h0);
        set0(1'b1, 4'h0, 9'h1FF, 32'h0); settle();
        chk("t6_r0_gnt", 32'(r0_gnt), 32'd1);
        next_cycle();
        set0(1'b0, 4'h0, 9'h000, 32'h0); settle();
        chk("t6_rvalid", 32'(r0_rvalid), 32'd1);
        chk("t6_rdata", r0_rdata, 32'h12345678);
        $display("t6 raw 0x1ff -> %h", r0_rdata);

        // 4: reset during a pending read return.
        next_cycle();
        set0(1'b1, 4'h0, 9'h005, 32'h0); settle();
        chk("t4_rd_gnt", 32'(r0_gnt), 32'd1);
        next_cycle();
        RST = 1'b1;
        set0(1'b0, 4'h0, 9'h000, 32'h0);
        set1(1'b1, 4'h0, 9'h002, 32'h0); settle();
        chk("t4_rvalid_in_rst", 32'(r0_rvalid), 32'd0);
        chk("t4_r1_gnt_in_rst", 32'(r1_gnt), 32'd0);
        chk("t4_ram_en_in_rst", 32'(ram_en), 32'd0);
        next_cycle();
        RST = 1'b0;
        set0(1'b1, 4'h0, 9'h001, 32'h0); settle();
        chk("t4_rvalid_after", 32'(r0_rvalid), 32'd0);
        chk("t4_rdata_cleared", r0_rdata, 32'h0);
        chk("t4_r1_rdata_cleared", r1_rdata, 32'h0);
        // After reset the first tie must go to port 0.
        chk("t4_first_tie_r0", 32'(r0_gnt), 32'd1);
        chk("t4_first_tie_r1", 32'(r1_gnt), 32'd0);
        $display("t4 reset mid-read checked");
        next_cycle();
        set0(1'b0, 4'h0, 9'h000, 32'h0); settle();
        chk("t4_r0_rvalid_after_rst", 32'(r0_rvalid), 32'd1);
        chk("t4_mem_kept_r0_rdata", r0_rdata, 32'h11);
        chk("t4_r1_served", 32'(r1_gnt), 32'd1);

`ifdef DFFRAM_ARB_FIXED_PRIO_EN
        // 5: fixed priority, both requesting for 4 cycles.
        next_cycle();
        set0(1'b1, 4'h0, 9'h001, 32'h0);
        set1(1'b1, 4'h0, 9'h002, 32'h0);
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("t5_r0_gnt", 32'(r0_gnt), 32'd1);
            chk("t5_r1_gnt", 32'(r1_gnt), 32'd0);
            $display("t5 cycle %0d r0_gnt=%0d r1_gnt=%0d", c, r0_gnt, r1_gnt);
            next_cycle();
        end
        set0(1'b0, 4'h0, 9'h000, 32'h0); settle();
        chk("t5_r1_after_drop", 32'(r1_gnt), 32'd1);
`else
        // Round-robin: a continuous tie alternates every cycle.
        next_cycle();
        set0(1'b1, 4'h0, 9'h001, 32'h0);
        set1(1'b1, 4'h0, 9'h002, 32'h0);
        for (int c = 0; c < 4; c++) begin
            settle();
            // last winner was r1 (previous step), so r0 wins on even cycles
            chk("rr_r0_gnt", 32'(r0_gnt), 32'((c % 2) == 0));
            chk("rr_r1_gnt", 32'(r1_gnt), 32'((c % 2) == 1));
            $display("rr cycle %0d r0_gnt=%0d r1_gnt=%0d", c, r0_gnt, r1_gnt);
            next_cycle();
        end
        set0(1'b0, 4'h0, 9'h000, 32'h0);
        set1(1'b0, 4'h0, 9'h000, 32'h0);
`endif

        // Dropped request before grant must leave no trace.
        next_cycle(); settle();
        next_cycle(); settle();
        chk("idle_ram_en", 32'(ram_en), 32'd0);
        chk("idle_no_rvalid", 32'(r0_rvalid | r1_rvalid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
